seg_scan_driver: RTL

- Time-multiplexed scanner for the board's 4-digit 7-segment display.
- Takes a 16-bit value from the CPU/debug side, double-buffers it, and cycles one digit at a time.
- Each cycle it presents the selected nibble on `hex` to the downstream hex-to-segment decoder and drives the active-low digit anodes.
- New values take effect only at frame boundaries, so a digit never shows a torn value.

---
 rtl/seg_scan_driver.sv | 114 +++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for a DIGITS-digit 7-segment display with a double-buffered value.
// Optional leading-zero blanking is compiled in when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
  parameter int CLK_DIV = 100000,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic                  pend_full,
  output logic [3:0]            hex,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

  logic [PW-1:0] pre;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic          tick;
  logic          boundary;
  logic [W-1:0]  disp;
  logic [W-1:0]  pend;
  logic [W-1:0]  disp_next;
  logic          slot_blank;

  assign tick      = (pre == PRE_MAX);
  assign boundary  = tick && (idx == IDX_MAX);
  assign idx_next  = (idx == IDX_MAX) ? '0 : idx + 1'b1;
  // Value the display holds after this edge; outputs are built from it so the
  // first slot of a frame already shows a freshly committed value.
  assign disp_next = (boundary && pend_full) ? pend : disp;

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] blank;
  logic              hi_zero;

  // Digit k is blank when it and every more significant nibble are zero.
  always_comb begin
    blank   = '0;
    hi_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      hi_zero  = hi_zero && (disp_next[4*k +: 4] == 4'h0);
      blank[k] = hi_zero;
    end
  end

  assign slot_blank = blank[idx_next];
`else
  assign slot_blank = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= IDX_MAX;
    end else if (tick) begin
      idx <= idx_next;
    end
  end

  // A write in the boundary cycle lands in pend after the old value commits,
  // so pend_full stays set in that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else begin
      disp <= disp_next;
      if (wr_en) begin
        pend      <= wr_data;
        pend_full <= 1'b1;
      end else if (boundary) begin
        pend_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex <= 4'h0;
      dp  <= 1'b0;
      an  <= '1;
    end else if (tick) begin
      if (slot_blank) begin
        hex <= 4'h0;
        dp  <= 1'b0;
        an  <= '1;
      end else begin
        hex <= disp_next[{idx_next, 2'b00} +: 4];
        dp  <= dp_mask[idx_next];
        an  <= ~(DIGITS'(1) << idx_next);
      end
    end
  end

endmodule
